// File: rtl/spi_sched_pkg.sv
// Shared types for the SPI host scheduler: FSM state encoding and a
// one-hot to index helper sized for the largest supported requester count.
package spi_sched_pkg;

    // Widest requester vector the helper below understands.
    localparam int MAX_REQ = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Index of the set bit of a one-hot vector; returns 0 for an all-zero vector.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (oh[k]) begin
                idx = 3'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/spi_sched_rr_pick.sv
// Combinational round-robin picker: returns the first requester with req set
// at or after ptr, wrapping modulo N_REQ.
module spi_sched_rr_pick
    import spi_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    // cand[k] is the requester index k positions after ptr, wrapped.
    logic [IW:0]   sum  [N_REQ];
    logic [IW-1:0] cand [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign sum[gi]  = {1'b0, ptr} + (IW+1)'(gi);
            assign cand[gi] = (sum[gi] >= (IW+1)'(N_REQ))
                            ? IW'(sum[gi] - (IW+1)'(N_REQ))
                            : sum[gi][IW-1:0];
        end
    endgenerate

    // Scan from the farthest candidate back to ptr so the closest requester wins.
    always_comb begin
        idx = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                idx = cand[k];
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/spi_host_scheduler.sv
// Round-robin scheduler sharing one SPI host between N_REQ requesters.
// Each grant becomes a single-frame host transaction; the received frame is
// returned to the granted requester with a one-cycle done pulse, followed by
// a GAP_CYCLES idle gap before the next grant.
// Optional feature: define SPI_SCHED_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT cycles, completing with rsp_err=1 and rsp_data=0 on expiry.
module spi_host_scheduler
    import spi_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic                        rsp_err,
    output logic                        busy,
    output logic                        host_tx_start,
    output logic [DATA_WIDTH-1:0]       host_tx_data,
    input  logic                        host_tx_done,
    input  logic [DATA_WIDTH-1:0]       host_rx_data
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    state_t                  state_q;
    logic [IW-1:0]           ptr_q;
    logic [IW-1:0]           ptr_d;
    logic [N_REQ-1:0]        gnt_q;
    logic [N_REQ-1:0]        gnt_d;
    logic [N_REQ-1:0]        done_q;
    logic [DATA_WIDTH-1:0]   tx_data_q;
    logic [DATA_WIDTH-1:0]   tx_data_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    tx_start_q;
    logic                    busy_q;
    logic [GW-1:0]           gap_cnt_q;
    logic                    gap_last;

    logic [IW-1:0]           pick_idx;
    logic                    pick_valid;
    logic [IW-1:0]           gnt_idx;

    spi_sched_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Grant and frame for the requester chosen this cycle.
    assign gnt_d     = N_REQ'(1) << pick_idx;
    assign tx_data_d = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];

    // The pointer moves to the requester after the one just served.
    assign gnt_idx = IW'(onehot_to_idx(MAX_REQ'(gnt_q)));
    assign ptr_d   = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + IW'(1);

    assign gap_last = (int'(gap_cnt_q) >= GAP_CYCLES - 1);

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt_q;
    logic          rsp_err_q;
    logic          wait_expired;

    // Expires on the TIMEOUT-th WAIT cycle without a host completion.
    assign wait_expired = (int'(wait_cnt_q) >= TIMEOUT - 1);
    assign rsp_err      = rsp_err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT > 0);
    assign rsp_err        = 1'b0;
`endif

    // Main transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            rsp_data_q <= '0;
            busy_q     <= 1'b0;
            gap_cnt_q  <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
            wait_cnt_q <= '0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q    <= START;
                        gnt_q      <= gnt_d;
                        tx_data_q  <= tx_data_d;
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    // A host_tx_done seen here belongs to nothing and is dropped.
                    state_q <= WAIT;
`ifdef SPI_SCHED_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                WAIT: begin
                    if (host_tx_done) begin
                        state_q    <= RESP;
                        done_q     <= gnt_q;
                        rsp_data_q <= host_rx_data;
`ifdef SPI_SCHED_TIMEOUT_EN
                        rsp_err_q  <= 1'b0;
                    end else if (wait_expired) begin
                        state_q    <= RESP;
                        done_q     <= gnt_q;
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TW'(1);
`endif
                    end
                end
                RESP: begin
                    gnt_q <= '0;
                    ptr_q <= ptr_d;
                    if (GAP_CYCLES == 0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q   <= GAP;
                        gap_cnt_q <= '0;
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt           = gnt_q;
    assign done          = done_q;
    assign rsp_data      = rsp_data_q;
    assign busy          = busy_q;
    assign host_tx_start = tx_start_q;
    assign host_tx_data  = tx_data_q;

endmodule

// File: tb/tb_spi_host_scheduler.sv
// Scoreboard bench for spi_host_scheduler: stimulus queues the expected
// host starts and requester completions, a monitor pops and compares them
// as the DUT presents them, and a host model answers each frame.
module tb_spi_host_scheduler;

    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int GAP   = 2;
    localparam int TMO   = 16;

    logic               clk;
    logic               rst;
    logic [N_REQ-1:0]   req;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;
    logic               busy;
    logic               host_tx_start;
    logic [DW-1:0]      host_tx_data;
    logic               host_tx_done;
    logic [DW-1:0]      host_rx_data;

    spi_host_scheduler #(
        .N_REQ      (N_REQ),
        .DATA_WIDTH (DW),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .done          (done),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .host_tx_start (host_tx_start),
        .host_tx_data  (host_tx_data),
        .host_tx_done  (host_tx_done),
        .host_rx_data  (host_rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N_REQ-1:0] gnt;
        logic [DW-1:0]    data;
    } start_t;

    typedef struct {
        logic [N_REQ-1:0] done;
        logic [DW-1:0]    data;
        logic             err;
        bit               lat;
    } done_t;

    start_t     exp_start_q[$];
    done_t      exp_done_q[$];
    logic [DW-1:0] rx_q[$];

    int  n_chk = 0;
    int  n_pass = 0;
    int  cyc = 0;
    int  nstart = 0;
    int  ndone = 0;
    int  last_start_cyc = 0;
    int  last_done_cyc = 0;
    int  txdone_cyc = 0;
    bit  have_done = 0;
    bit  gap_check_en = 0;
    bit  host_mute = 0;
    bit  spur_start = 0;
    int  host_delay = 4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_event(input string name);
        n_chk++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    task automatic expect_frame(input logic [N_REQ-1:0] g, input logic [DW-1:0] tx,
                                input logic [DW-1:0] rx, input logic err, input bit lat);
        start_t s;
        done_t  d;
        s.gnt = g;  s.data = tx;
        d.done = g; d.data = rx; d.err = err; d.lat = lat;
        exp_start_q.push_back(s);
        exp_done_q.push_back(d);
        if (lat) rx_q.push_back(rx);
    endtask

    task automatic set_slot(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic wait_start(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (nstart >= target) return;
        end
        check("wait_start_timeout", nstart, target);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (ndone >= target) return;
        end
        check("wait_done_timeout", ndone, target);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (!busy) return;
        end
        check("wait_idle_timeout", busy, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        have_done = 0;
    endtask

    // Cycle counter advanced on every active edge.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Host model: answers each start after host_delay cycles with the next queued frame.
    initial begin
        host_tx_done = 1'b0;
        host_rx_data = '0;
        forever begin
            @(negedge clk);
            if (!rst && host_tx_start && !host_mute) begin
                if (spur_start) begin
                    host_tx_done = 1'b1;
                    host_rx_data = 8'hEE;
                    @(negedge clk);
                    host_tx_done = 1'b0;
                end
                repeat (host_delay) @(negedge clk);
                if (!rst && !host_mute) begin
                    host_rx_data = 8'h00;
                    if (rx_q.size() > 0) host_rx_data = rx_q.pop_front();
                    host_tx_done = 1'b1;
                    txdone_cyc   = cyc;
                    @(negedge clk);
                    host_tx_done = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every host start and every completion against the scoreboard.
    initial forever begin
        start_t s;
        done_t  d;
        @(negedge clk);
        if (!rst) begin
            if (host_tx_start) begin
                if (exp_start_q.size() == 0) begin
                    fail_event("unexpected_start");
                end else begin
                    s = exp_start_q.pop_front();
                    check("start_gnt", gnt, s.gnt);
                    check("start_data", host_tx_data, s.data);
                    $display("start  cyc=%0d gnt=%b data=%h", cyc, gnt, host_tx_data);
                end
                if (gap_check_en && have_done)
                    check("gap_done_to_start", cyc - last_done_cyc, GAP + 2);
                last_start_cyc = cyc;
                nstart++;
            end
            if (done != '0) begin
                if (exp_done_q.size() == 0) begin
                    fail_event("unexpected_done");
                end else begin
                    d = exp_done_q.pop_front();
                    check("done_vec", done, d.done);
                    check("resp_gnt", gnt, d.done);
                    check("rsp_data", rsp_data, d.data);
                    check("rsp_err", rsp_err, d.err);
                    if (d.lat) check("done_latency", cyc - txdone_cyc, 1);
                    $display("done   cyc=%0d done=%b data=%h err=%b", cyc, done, rsp_data, rsp_err);
                end
                last_done_cyc = cyc;
                have_done = 1;
                ndone++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_start", host_tx_start, 0);
        check("rst_tx_data", host_tx_data, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        @(negedge clk); #1;
        rst = 1'b0;

        // Single request from requester 1.
        set_slot(1, 8'hA5);
        host_delay = 20;
        expect_frame(4'b0010, 8'hA5, 8'h3C, 1'b0, 1);
        req = 4'b0010;
        @(negedge clk); #1;
        check("single_gnt_latency", gnt, 4'b0010);
        check("single_start_latency", host_tx_start, 1);
        check("single_busy", busy, 1);
        wait_done(1, 100);
        req = '0;
        wait_idle(20);

        // Spurious host_tx_done while idle.
        host_tx_done = 1'b1;
        host_rx_data = 8'h77;
        @(negedge clk); #1;
        host_tx_done = 1'b0;
        check("spur_idle_busy", busy, 0);
        check("spur_idle_done", done, 0);
        @(negedge clk); #1;
        check("spur_idle_done2", done, 0);
        check("rsp_data_hold", rsp_data, 8'h3C);

        // Contention: all four held, order 0,1,2,3,0 with a fixed gap.
        apply_reset();
        for (int i = 0; i < N_REQ; i++) set_slot(i, 8'h10 + 8'(i));
        host_delay = 3;
        expect_frame(4'b0001, 8'h10, 8'hE0, 1'b0, 1);
        expect_frame(4'b0010, 8'h11, 8'hE1, 1'b0, 1);
        expect_frame(4'b0100, 8'h12, 8'hE2, 1'b0, 1);
        expect_frame(4'b1000, 8'h13, 8'hE3, 1'b0, 1);
        expect_frame(4'b0001, 8'h10, 8'hE4, 1'b0, 1);
        gap_check_en = 1;
        req = 4'b1111;
        wait_done(ndone + 5, 200);
        req = '0;
        gap_check_en = 0;
        wait_idle(20);

        // Withdrawal during WAIT, with a spurious host_tx_done during START.
        set_slot(2, 8'h5A);
        host_delay = 6;
        spur_start = 1;
        expect_frame(4'b0100, 8'h5A, 8'hC3, 1'b0, 1);
        req = 4'b0100;
        wait_start(nstart + 1, 20);
        @(negedge clk); #1;
        check("spur_start_done", done, 0);
        check("spur_start_busy", busy, 1);
        spur_start = 0;
        @(negedge clk); #1;
        req = '0;
        wait_done(ndone + 1, 50);
        wait_idle(20);

        // Pointer now 3: req 1001 is served 3 then 0.
        set_slot(0, 8'h61);
        set_slot(3, 8'h63);
        host_delay = 2;
        expect_frame(4'b1000, 8'h63, 8'h83, 1'b0, 1);
        expect_frame(4'b0001, 8'h61, 8'h81, 1'b0, 1);
        req = 4'b1001;
        wait_done(ndone + 2, 100);
        req = '0;
        wait_idle(20);

`ifdef SPI_SCHED_TIMEOUT_EN
        // Host never completes: abort after exactly TMO WAIT cycles.
        set_slot(0, 8'h99);
        host_mute = 1;
        expect_frame(4'b0001, 8'h99, 8'h00, 1'b1, 0);
        req = 4'b0001;
        wait_start(nstart + 1, 20);
        wait_done(ndone + 1, 100);
        check("timeout_latency", last_done_cyc - last_start_cyc, TMO + 1);
        req = '0;
        host_mute = 0;
        wait_idle(20);
        set_slot(1, 8'h42);
        expect_frame(4'b0010, 8'h42, 8'h24, 1'b0, 1);
        req = 4'b0010;
        wait_done(ndone + 1, 50);
        req = '0;
        wait_idle(20);
`endif

        // Reset in the middle of WAIT.
        set_slot(2, 8'hB7);
        host_mute = 1;
        expect_frame(4'b0100, 8'hB7, 8'h00, 1'b0, 0);
        req = 4'b0100;
        wait_start(nstart + 1, 20);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_gnt", gnt, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_start", host_tx_start, 0);
        exp_done_q.delete();
        req = '0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        host_mute = 0;

        // Pointer back at 0: req 0011 is served by requester 0.
        set_slot(0, 8'hD0);
        set_slot(1, 8'hD1);
        host_delay = 2;
        expect_frame(4'b0001, 8'hD0, 8'h5D, 1'b0, 1);
        req = 4'b0011;
        wait_done(ndone + 1, 50);
        req = '0;
        wait_idle(20);
        repeat (5) @(negedge clk);
        #1;

        check("start_queue_empty", exp_start_q.size(), 0);
        check("done_queue_empty", exp_done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
